// File: rtl/sensor_sched_pkg.sv
// Shared types and constants for the sensor transmit scheduler: FSM encoding,
// default geometry and a width helper.
package sensor_sched_pkg;

   localparam int DEF_N_CH   = 8;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_START = 2'd2,
      ST_WAIT  = 2'd3
   } sched_state_t;

   // Ceil-log2 with a floor of 1 so a single channel still gets a 1-bit index.
   function automatic int clog2_min1(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sensor_rr_arbiter.sv
// Combinational round-robin search: first requesting channel at or above ptr,
// wrapping to the lowest requester when none is found above it.
module sensor_rr_arbiter
   import sensor_sched_pkg::*;
#(
   parameter  int N_CH = DEF_N_CH,
   localparam int CH_W = clog2_min1(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   output logic [CH_W-1:0] gnt_idx,
   output logic            gnt_vld
);

   logic [N_CH-1:0] masked;
   logic            hi_vld;
   logic            lo_vld;
   logic [CH_W-1:0] hi_idx;
   logic [CH_W-1:0] lo_idx;

   always_comb begin
      masked = '0;
      hi_vld = 1'b0;
      lo_vld = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = 0; i < N_CH; i++) begin
         masked[i] = req[i] && (i >= int'(ptr));
      end
      // Scan downward so the last hit is the lowest index.
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (masked[i]) begin
            hi_vld = 1'b1;
            hi_idx = CH_W'(i);
         end
         if (req[i]) begin
            lo_vld = 1'b1;
            lo_idx = CH_W'(i);
         end
      end
      gnt_vld = lo_vld;
      gnt_idx = hi_vld ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/sensor_tx_scheduler.sv
// Round-robin scheduler feeding sensor channel words into one UART transmitter.
// Optional wait-for-done watchdog enabled by defining SENSOR_TX_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no transfer; grant the next ready channel and latch its word
//   ST_GRANT | ch_ack high for the granted channel
//   ST_START | tx_start high for one cycle
//   ST_WAIT  | hold tx_data/tx_ch until tx_done (or watchdog expiry)
module sensor_tx_scheduler
   import sensor_sched_pkg::*;
#(
   parameter  int          N_CH        = DEF_N_CH,
   parameter  int          DATA_W      = DEF_DATA_W,
   parameter  int unsigned TIMEOUT_CYC = 5000000,
   localparam int          CH_W        = clog2_min1(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH-1:0]        ch_ready,
   input  logic [N_CH*DATA_W-1:0] ch_data,
   output logic [N_CH-1:0]        ch_ack,
   output logic [DATA_W-1:0]      tx_data,
   output logic [CH_W-1:0]        tx_ch,
   output logic                   tx_start,
   input  logic                   tx_done,
   output logic                   busy,
   output logic                   tx_timeout
);

   sched_state_t      state, state_nxt;
   logic [CH_W-1:0]   ptr, ptr_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic [CH_W-1:0]   ch_nxt;
   logic [N_CH-1:0]   ack_nxt;
   logic              start_nxt;
   logic              timeout_nxt;
   logic [CH_W-1:0]   gnt_idx;
   logic              gnt_vld;
   logic [CH_W-1:0]   ptr_after;

   sensor_rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req     (ch_ready),
      .ptr     (ptr),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // Pointer moves just past the channel that was served.
   assign ptr_after = (tx_ch == CH_W'(N_CH - 1)) ? '0 : tx_ch + 1'b1;
   assign busy      = (state != ST_IDLE);

`ifdef SENSOR_TX_TIMEOUT_EN
   logic [31:0] wait_cnt, wait_cnt_nxt;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      data_nxt    = tx_data;
      ch_nxt      = tx_ch;
      ack_nxt     = '0;
      start_nxt   = 1'b0;
      timeout_nxt = 1'b0;
`ifdef SENSOR_TX_TIMEOUT_EN
      wait_cnt_nxt = wait_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (gnt_vld) begin
               data_nxt         = ch_data[int'(gnt_idx)*DATA_W +: DATA_W];
               ch_nxt           = gnt_idx;
               ack_nxt[gnt_idx] = 1'b1;
               state_nxt        = ST_GRANT;
            end
         end
         ST_GRANT: begin
            start_nxt = 1'b1;
            state_nxt = ST_START;
         end
         ST_START: begin
            state_nxt = ST_WAIT;
`ifdef SENSOR_TX_TIMEOUT_EN
            wait_cnt_nxt = '0;
`endif
         end
         ST_WAIT: begin
            if (tx_done) begin
               ptr_nxt   = ptr_after;
               state_nxt = ST_IDLE;
            end
`ifdef SENSOR_TX_TIMEOUT_EN
            else if (wait_cnt == 32'(TIMEOUT_CYC - 1)) begin
               ptr_nxt     = ptr_after;
               timeout_nxt = 1'b1;
               state_nxt   = ST_IDLE;
            end else begin
               wait_cnt_nxt = wait_cnt + 32'd1;
            end
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         tx_data    <= '0;
         tx_ch      <= '0;
         ch_ack     <= '0;
         tx_start   <= 1'b0;
         tx_timeout <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         tx_data    <= data_nxt;
         tx_ch      <= ch_nxt;
         ch_ack     <= ack_nxt;
         tx_start   <= start_nxt;
         tx_timeout <= timeout_nxt;
      end
   end

`ifdef SENSOR_TX_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt <= '0;
      else        wait_cnt <= wait_cnt_nxt;
   end
`endif

endmodule

// File: tb/tb_sensor_tx_scheduler.sv
// Directed bench for sensor_tx_scheduler (8 channels, 16-bit words, short watchdog).
module tb_sensor_tx_scheduler;

   logic         clk;
   logic         rst_n;
   logic [7:0]   ch_ready;
   logic [127:0] ch_data;
   logic [7:0]   ch_ack;
   logic [15:0]  tx_data;
   logic [2:0]   tx_ch;
   logic         tx_start;
   logic         tx_done;
   logic         busy;
   logic         tx_timeout;

   int checks   = 0;
   int failures = 0;

   sensor_tx_scheduler #(.N_CH(8), .DATA_W(16), .TIMEOUT_CYC(20)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ch_ready   (ch_ready),
      .ch_data    (ch_data),
      .ch_ack     (ch_ack),
      .tx_data    (tx_data),
      .tx_ch      (tx_ch),
      .tx_start   (tx_start),
      .tx_done    (tx_done),
      .busy       (busy),
      .tx_timeout (tx_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wait (bounded) for an ack; returns at the negedge of the GRANT cycle, ch=-1 on timeout.
   task automatic grab(output int ch, output logic [7:0] ack, output logic [15:0] data);
      ch = -1; ack = '0; data = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ch_ack != 8'h00) begin
            ch = int'(tx_ch); ack = ch_ack; data = tx_data;
            break;
         end
      end
   endtask

   // From the GRANT negedge: pass START, wait dly cycles, pulse tx_done.
   task automatic finish_word(input int dly);
      @(negedge clk);
      repeat (dly) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ch_ready = '0; tx_done = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ch_ready = 8'hFF; tx_done = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ch_ack, tx_data, tx_ch, tx_start, busy, tx_timeout} !== 31'd0) begin
         failures++;
         $display("FAIL reset_outputs: got ack=%h data=%h ch=%0d start=%b busy=%b tout=%b, want all 0",
                  ch_ack, tx_data, tx_ch, tx_start, busy, tx_timeout);
      end
      ch_ready = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int ch; logic [7:0] ack; logic [15:0] d;
      ch_data[2*16 +: 16] = 16'h2D7F;
      ch_ready = 8'h04;
      @(negedge clk);
      checks++;
      if (ch_ack !== 8'h04 || tx_data !== 16'h2D7F || tx_ch !== 3'd2 || !busy || tx_start) begin
         failures++;
         $display("FAIL single_grant: ack=%h data=%h ch=%0d busy=%b start=%b, want 04 2d7f 2 1 0",
                  ch_ack, tx_data, tx_ch, busy, tx_start);
      end
      ch_ready = 8'h00;
      @(negedge clk);
      checks++;
      if (ch_ack !== 8'h00 || tx_start !== 1'b1) begin
         failures++;
         $display("FAIL single_start: ack=%h start=%b, want 00 1", ch_ack, tx_start);
      end
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 16'h2D7F) begin
         failures++;
         $display("FAIL single_wait: start=%b busy=%b data=%h, want 0 1 2d7f", tx_start, busy, tx_data);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL single_done_idle: busy=%b want 0", busy);
      end
      // ptr should now be 3: ch0 and ch3 ready must pick ch3.
      ch_data[3*16 +: 16] = 16'h3333;
      ch_ready = 8'h09;
      grab(ch, ack, d);
      ch_ready = 8'h00;
      checks++;
      if (ch != 3 || ack !== 8'h08 || d !== 16'h3333) begin
         failures++;
         $display("FAIL single_ptr_next: ch=%0d ack=%h data=%h, want 3 08 3333", ch, ack, d);
      end
      finish_word(2);
   endtask

   task automatic test_round_robin();
      int ch; logic [7:0] ack; logic [15:0] d; int exp;
      for (int i = 0; i < 8; i++) ch_data[i*16 +: 16] = 16'hA000 + 16'(i);
      ch_ready = 8'hFF;
      // ptr is 4 after the previous test; start from 4 then wrap through 0..7,0.
      for (int g = 0; g < 13; g++) begin
         exp = (g + 4) % 8;
         grab(ch, ack, d);
         checks++;
         if (ch != exp || ack !== (8'h01 << exp) || d !== (16'hA000 + 16'(exp))) begin
            failures++;
            $display("FAIL rr_grant%0d: ch=%0d ack=%h data=%h, want %0d %h %h",
                     g, ch, ack, d, exp, 8'h01 << exp, 16'hA000 + 16'(exp));
         end
         finish_word(10);
      end
      ch_ready = 8'h00;
   endtask

   task automatic test_wrap_skip();
      int ch; logic [7:0] ack; logic [15:0] d;
      // ptr is 1; serve ch5 to bring ptr to 6.
      ch_ready = 8'h20;
      grab(ch, ack, d);
      ch_ready = 8'h00;
      checks++;
      if (ch != 5) begin
         failures++;
         $display("FAIL wrap_setup: ch=%0d want 5", ch);
      end
      finish_word(1);
      ch_ready = 8'h21;
      grab(ch, ack, d);
      checks++;
      if (ch != 0 || ack !== 8'h01) begin
         failures++;
         $display("FAIL wrap_first: ch=%0d ack=%h, want 0 01", ch, ack);
      end
      finish_word(1);
      grab(ch, ack, d);
      ch_ready = 8'h00;
      checks++;
      if (ch != 5 || ack !== 8'h20) begin
         failures++;
         $display("FAIL wrap_second: ch=%0d ack=%h, want 5 20", ch, ack);
      end
      finish_word(1);
   endtask

   task automatic test_done_ignored();
      int ch; logic [7:0] ack; logic [15:0] d;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ch_ack !== 8'h00) begin
         failures++;
         $display("FAIL done_in_idle: busy=%b ack=%h, want 0 00", busy, ch_ack);
      end
      ch_ready = 8'h80;
      grab(ch, ack, d);
      ch_ready = 8'h00;
      checks++;
      if (ch != 7) begin
         failures++;
         $display("FAIL done_grant: ch=%0d want 7", ch);
      end
      @(negedge clk);
      tx_done = tx_start;   // pulse exactly in the START cycle
      @(negedge clk);
      tx_done = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL done_in_start: busy=%b want 1", busy);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || tx_ch !== 3'd7) begin
         failures++;
         $display("FAIL done_hold_wait: busy=%b ch=%0d, want 1 7", busy, tx_ch);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL done_release: busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_in_wait();
      int ch; logic [7:0] ack; logic [15:0] d;
      // ptr is 0; serve ch3 so ptr becomes 4, then hold ch5 in WAIT.
      ch_ready = 8'h08;
      grab(ch, ack, d);
      ch_ready = 8'h00;
      finish_word(1);
      ch_ready = 8'h21;
      grab(ch, ack, d);
      ch_ready = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (ch != 5 || tx_ch !== 3'd5 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rstwait_setup: ch=%0d tx_ch=%0d busy=%b, want 5 5 1", ch, tx_ch, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ch_ack, tx_data, tx_ch, tx_start, busy, tx_timeout} !== 31'd0) begin
         failures++;
         $display("FAIL rstwait_outputs: ack=%h data=%h ch=%0d start=%b busy=%b tout=%b, want all 0",
                  ch_ack, tx_data, tx_ch, tx_start, busy, tx_timeout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      ch_ready = 8'h21;
      grab(ch, ack, d);
      ch_ready = 8'h00;
      checks++;
      if (ch != 0 || ack !== 8'h01) begin
         failures++;
         $display("FAIL rstwait_ptr0: ch=%0d ack=%h, want 0 01", ch, ack);
      end
      finish_word(1);
   endtask

   task automatic test_timeout();
      int ch; logic [7:0] ack; logic [15:0] d;
      do_reset();
      ch_ready = 8'h03;
      grab(ch, ack, d);
      checks++;
      if (ch != 0) begin
         failures++;
         $display("FAIL tout_first: ch=%0d want 0", ch);
      end
      @(negedge clk);   // START cycle
`ifdef SENSOR_TX_TIMEOUT_EN
      repeat (20) @(negedge clk);
      checks++;
      if (tx_timeout !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL tout_early: tout=%b busy=%b, want 0 1", tx_timeout, busy);
      end
      @(negedge clk);
      checks++;
      if (tx_timeout !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL tout_pulse: tout=%b busy=%b, want 1 0", tx_timeout, busy);
      end
      grab(ch, ack, d);
      ch_ready = 8'h00;
      checks++;
      if (ch != 1 || ack !== 8'h02) begin
         failures++;
         $display("FAIL tout_next: ch=%0d ack=%h, want 1 02", ch, ack);
      end
      finish_word(1);
`else
      ch_ready = 8'h00;
      repeat (30) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || tx_timeout !== 1'b0) begin
         failures++;
         $display("FAIL notout_hold: busy=%b tout=%b, want 1 0", busy, tx_timeout);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
`endif
   endtask

   initial begin
      ch_data  = '0;
      ch_ready = '0;
      tx_done  = 1'b0;
      rst_n    = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap_skip();
      test_done_ignored();
      test_reset_in_wait();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
